// File: rtl/rx_frame_sr.sv
// rx_frame_sr: UART receive frame shifter and checker.
// Captures one serial frame LSB first on bit-centre strobes, checks parity
// and stop bits, then presents the data word through a ready/read handshake.
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   frame_start          1-cycle pulse, validated start bit seen
//   shift_strobe         1-cycle pulse, sample serial_in
//   serial_in            synchronised rx line
//   data_read            1-cycle pulse, consumer took packet_data
//   packet_data          last received data word
//   data_ready           packet_data holds an unread word
//   parity_err           parity mismatch on the current word
//   framing_err          a stop bit sampled 0 on the current word
//   overrun_err          sticky, a word was overwritten before being read
//   busy                 frame capture in progress
module rx_frame_sr #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic                 shift_strobe,
    input  logic                 serial_in,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] packet_data,
    output logic                 data_ready,
    output logic                 parity_err,
    output logic                 framing_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int unsigned FRAME_LEN = DATA_BITS + PARITY_EN + STOP_BITS;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t                 r_state;
    logic [FRAME_LEN-1:0]   r_shift;
    logic [CNT_W-1:0]       r_cnt;

    logic [DATA_BITS-1:0]   w_data;
    logic                   w_par_bit;
    logic [STOP_BITS-1:0]   w_stop;
    logic                   w_par_err;

    // Field extraction from the full shift register: data low, parity, stops on top.
    assign w_data    = r_shift[DATA_BITS-1:0];
    assign w_par_bit = (PARITY_EN != 0) ? r_shift[DATA_BITS] : 1'b0;
    assign w_stop    = r_shift[FRAME_LEN-1 -: STOP_BITS];
    assign w_par_err = (PARITY_EN != 0) && ((^{w_data, w_par_bit}) != 1'(PARITY_ODD));

    assign busy = (r_state != S_IDLE);

    // Frame capture FSM plus output holding register and handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '1;
            r_cnt       <= '0;
            packet_data <= '0;
            data_ready  <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A strobe coinciding with frame_start is deliberately dropped.
                    if (frame_start) begin
                        r_state <= S_SHIFT;
                        r_cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    if (shift_strobe) begin
                        r_shift <= {serial_in, r_shift[FRAME_LEN-1:1]};
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(FRAME_LEN - 1)) begin
                            r_state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (r_state == S_CHECK) begin
                // Load wins over a simultaneous read; only an unread overwrite flags overrun.
                packet_data <= w_data;
                parity_err  <= w_par_err;
                framing_err <= ~&w_stop;
                data_ready  <= 1'b1;
                if (data_ready && !data_read) begin
                    overrun_err <= 1'b1;
                end else if (data_ready && data_read) begin
                    overrun_err <= 1'b0;
                end
            end else if (data_read && data_ready) begin
                data_ready  <= 1'b0;
                overrun_err <= 1'b0;
            end
        end
    end

endmodule
